store_buffer_unit: RTL and testbench

- Parametrised successor to the combinational store aligner in the MEM stage.
- Aligns store data and byte strobes for any XLEN, then queues them in a DEPTH-entry FIFO. Drains them to data memory over a valid/ready handshake.
- Lets the pipeline retire stores without waiting on memory.
- Detects stores that cross a word boundary; with the optional feature enabled, splits them into two beats.

---
 rtl/store_pkg.sv | 29 ++
 rtl/store_lane_align.sv | 39 +++
 rtl/store_buffer_unit.sv | 128 ++++++++++++
 tb/tb_store_buffer_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store buffer: funct3 encodings, access-size decode
// and the queued entry layout, sized for the widest XLEN/AW in use.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam int MAX_XLEN = 64;
  localparam int MAX_AW   = 64;

  // Entries are stored zero-extended to the maximum widths so one type serves every build.
  typedef struct packed {
    logic [MAX_AW-1:0]     addr;
    logic [MAX_XLEN-1:0]   wdata;
    logic [MAX_XLEN/8-1:0] wstrb;
  } entry_t;

  function automatic logic [3:0] sizeBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   sizeBytes = 4'd1;
      2'b01:   sizeBytes = 4'd2;
      2'b10:   sizeBytes = 4'd4;
      default: sizeBytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store aligner: shifts data/strobes into byte lanes for both
// beats of a possibly word-crossing store and flags crossing/illegal requests.
module store_lane_align
  import store_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OW   = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] data0,
  output logic [XLEN-1:0] data1,
  output logic [NB-1:0]   strb0,
  output logic [NB-1:0]   strb1,
  output logic            crossing,
  output logic            illegal
);

  logic [3:0]        sz;
  logic [2*NB-1:0]   baseMask;
  logic [2*NB-1:0]   wideStrb;
  logic [2*XLEN-1:0] wideData;

  assign sz       = sizeBytes(funct3);
  assign baseMask = (2*NB)'((16'd1 << sz) - 16'd1);
  assign wideStrb = baseMask << off;
  // The upper half of the double-width shift is exactly wdata >> 8*(NB-off).
  assign wideData = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

  assign data0    = wideData[XLEN-1:0];
  assign data1    = wideData[2*XLEN-1:XLEN];
  assign strb0    = wideStrb[NB-1:0];
  assign strb1    = wideStrb[2*NB-1:NB];
  assign crossing = (6'(off) + 6'(sz)) > 6'(NB);
  assign illegal  = funct3[2] | ((funct3[1:0] == 2'b11) && (XLEN == 32));

endmodule

// File: rtl/store_buffer_unit.sv
// Store buffer: aligns MEM-stage stores and queues them for data memory.
// Define STORE_SPLIT_MISALIGN_EN to split word-crossing stores into two beats
// instead of faulting them.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic [AW-1:0]            req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  output logic                     store_fault,
  output logic [AW-1:0]            fault_addr,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] data0, data1;
  logic [NB-1:0]   strb0, strb1;
  logic            crossing, illegal;
  logic            isBad, splitReq, push, pop;
  logic [1:0]      pushN;
  logic [AW-1:0]   alignedAddr;
  entry_t          beat0, beat1, head;
  entry_t          fifo [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   cnt;
  logic            unusedBits;

  store_lane_align #(.XLEN(XLEN)) uAlign (
    .funct3   (req_funct3),
    .off      (req_addr[OW-1:0]),
    .wdata    (req_wdata),
    .data0    (data0),
    .data1    (data1),
    .strb0    (strb0),
    .strb1    (strb1),
    .crossing (crossing),
    .illegal  (illegal)
  );

  assign alignedAddr = {req_addr[AW-1:OW], {OW{1'b0}}};

  always_comb begin
    beat0       = '0;
    beat0.addr  = MAX_AW'(alignedAddr);
    beat0.wdata = MAX_XLEN'(data0);
    beat0.wstrb = (MAX_XLEN/8)'(strb0);
    beat1       = '0;
    beat1.addr  = MAX_AW'(alignedAddr + AW'(NB));
    beat1.wdata = MAX_XLEN'(data1);
    beat1.wstrb = (MAX_XLEN/8)'(strb1);
  end

`ifdef STORE_SPLIT_MISALIGN_EN
  assign isBad    = illegal;
  assign splitReq = crossing & ~illegal;
`else
  assign isBad    = illegal | crossing;
  assign splitReq = 1'b0;
`endif

  // Faulting requests are always accepted (and dropped) so the pipeline never stalls on them.
  always_comb begin
    if (isBad)         req_ready = 1'b1;
    else if (splitReq) req_ready = (cnt <= CW'(DEPTH - 2));
    else               req_ready = (cnt <= CW'(DEPTH - 1));
  end

  assign push  = req_valid & req_ready & ~isBad;
  assign pop   = mem_valid & mem_ready;
  assign pushN = push ? (splitReq ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        fifo[wrPtr] <= beat0;
        if (splitReq) fifo[wrPtr + PW'(1)] <= beat1;
      end
      wrPtr <= wrPtr + PW'(pushN);
      rdPtr <= rdPtr + PW'(pop);
      cnt   <= cnt + CW'(pushN) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      store_fault <= 1'b0;
      fault_addr  <= '0;
    end else begin
      store_fault <= req_valid & req_ready & isBad;
      if (req_valid && req_ready && isBad) fault_addr <= req_addr;
    end
  end

  assign head      = fifo[rdPtr];
  assign mem_valid = (cnt != '0);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign mem_addr  = head.addr[AW-1:0];
  assign mem_wdata = head.wdata[XLEN-1:0];
  assign mem_wstrb = head.wstrb[NB-1:0];

  // Upper bits of the max-width entry are never driven out; beat1 is idle without splitting.
  assign unusedBits = ^{head, beat1};

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed self-checking bench for store_buffer_unit (XLEN=32, DEPTH=4, AW=32).
module tb_store_buffer_unit;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        store_fault;
  logic [31:0] fault_addr;
  logic        empty;
  logic [2:0]  count;

  int nCmp = 0;
  int nErr = 0;

  store_buffer_unit #(.XLEN(32), .DEPTH(4), .AW(32)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .store_fault(store_fault), .fault_addr(fault_addr),
    .empty(empty), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  task automatic test_reset();
    RESETn = 1'b0; mem_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    nCmp++; if (empty !== 1'b1) begin nErr++; $display("FAIL reset_empty got %b want 1", empty); end
    nCmp++; if (mem_valid !== 1'b0) begin nErr++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL reset_count got %0d want 0", count); end
    nCmp++; if (store_fault !== 1'b0) begin nErr++; $display("FAIL reset_fault got %b want 0", store_fault); end
    nCmp++; if (fault_addr !== 32'h0) begin nErr++; $display("FAIL reset_fault_addr got %h want 0", fault_addr); end
    nCmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin nErr++; $display("FAIL reset_head got %h/%h/%b want 0", mem_addr, mem_wdata, mem_wstrb); end
    @(posedge CLK); #1;
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    mem_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h1003, 32'h0000_00AB);
    #1;
    nCmp++; if (req_ready !== 1'b1) begin nErr++; $display("FAIL sb_ready got %b want 1", req_ready); end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (mem_valid !== 1'b1) begin nErr++; $display("FAIL sb_valid got %b want 1", mem_valid); end
    nCmp++; if (mem_addr !== 32'h1000) begin nErr++; $display("FAIL sb_addr got %h want 00001000", mem_addr); end
    nCmp++; if (mem_wdata !== 32'hAB00_0000) begin nErr++; $display("FAIL sb_wdata got %h want ab000000", mem_wdata); end
    nCmp++; if (mem_wstrb !== 4'b1000) begin nErr++; $display("FAIL sb_wstrb got %b want 1000", mem_wstrb); end
    tick();
    nCmp++; if (empty !== 1'b1) begin nErr++; $display("FAIL sb_drained got empty=%b want 1", empty); end
  endtask

  task automatic test_sh();
    mem_ready = 1'b1;
    drive(1'b1, 3'b001, 32'h2001, 32'h0000_BEEF);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (mem_wstrb !== 4'b0110) begin nErr++; $display("FAIL sh_wstrb got %b want 0110", mem_wstrb); end
    nCmp++; if (mem_wdata !== 32'h00BE_EF00) begin nErr++; $display("FAIL sh_wdata got %h want 00beef00", mem_wdata); end
    nCmp++; if (mem_addr !== 32'h2000) begin nErr++; $display("FAIL sh_addr got %h want 00002000", mem_addr); end
    nCmp++; if (store_fault !== 1'b0) begin nErr++; $display("FAIL sh_fault got %b want 0", store_fault); end
    tick();
    nCmp++; if (empty !== 1'b1) begin nErr++; $display("FAIL sh_drained got empty=%b want 1", empty); end
  endtask

  task automatic test_full_drain();
    logic [31:0] a, d;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 32'h100 + 32'(4 * k);
      d = 32'h1111_1111 * 32'(k + 1);
      drive(1'b1, 3'b010, a, d);
      tick();
    end
    nCmp++; if (count !== 3'd4) begin nErr++; $display("FAIL full_count got %0d want 4", count); end
    drive(1'b1, 3'b010, 32'h110, 32'h5555_5555);
    #1;
    nCmp++; if (req_ready !== 1'b0) begin nErr++; $display("FAIL full_ready got %b want 0", req_ready); end
    tick();
    nCmp++; if (count !== 3'd4) begin nErr++; $display("FAIL stall_count got %0d want 4", count); end
    nCmp++; if (mem_addr !== 32'h100) begin nErr++; $display("FAIL stall_head got %h want 00000100", mem_addr); end
    // Pop offered with the fifth push still pending: full FIFO must refuse.
    mem_ready = 1'b1;
    #1;
    nCmp++; if (req_ready !== 1'b0) begin nErr++; $display("FAIL nobypass_ready got %b want 0", req_ready); end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (count !== 3'd3) begin nErr++; $display("FAIL pushpop_count got %0d want 3", count); end
    for (int k = 1; k < 4; k++) begin
      a = 32'h100 + 32'(4 * k);
      d = 32'h1111_1111 * 32'(k + 1);
      nCmp++; if (mem_addr !== a || mem_wdata !== d || mem_wstrb !== 4'hF)
        begin nErr++; $display("FAIL drain%0d got %h/%h/%b want %h/%h/1111", k, mem_addr, mem_wdata, mem_wstrb, a, d); end
      tick();
    end
    nCmp++; if (empty !== 1'b1 || count !== 3'd0) begin nErr++; $display("FAIL drain_end got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_cross();
    mem_ready = 1'b0;
    drive(1'b1, 3'b010, 32'h3002, 32'h1122_3344);
    #1;
    nCmp++; if (req_ready !== 1'b1) begin nErr++; $display("FAIL cross_ready got %b want 1", req_ready); end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
`ifdef STORE_SPLIT_MISALIGN_EN
    nCmp++; if (count !== 3'd2) begin nErr++; $display("FAIL split_count got %0d want 2", count); end
    nCmp++; if (store_fault !== 1'b0) begin nErr++; $display("FAIL split_fault got %b want 0", store_fault); end
    nCmp++; if (mem_addr !== 32'h3000 || mem_wdata !== 32'h3344_0000 || mem_wstrb !== 4'b1100)
      begin nErr++; $display("FAIL split_beat0 got %h/%h/%b want 00003000/33440000/1100", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    tick();
    nCmp++; if (mem_addr !== 32'h3004 || mem_wdata !== 32'h0000_1122 || mem_wstrb !== 4'b0011)
      begin nErr++; $display("FAIL split_beat1 got %h/%h/%b want 00003004/00001122/0011", mem_addr, mem_wdata, mem_wstrb); end
    tick();
    nCmp++; if (empty !== 1'b1) begin nErr++; $display("FAIL split_drained got empty=%b want 1", empty); end
`else
    nCmp++; if (store_fault !== 1'b1) begin nErr++; $display("FAIL cross_fault got %b want 1", store_fault); end
    nCmp++; if (fault_addr !== 32'h3002) begin nErr++; $display("FAIL cross_fault_addr got %h want 00003002", fault_addr); end
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL cross_count got %0d want 0", count); end
    tick();
    nCmp++; if (store_fault !== 1'b0) begin nErr++; $display("FAIL cross_pulse got %b want 0", store_fault); end
    nCmp++; if (fault_addr !== 32'h3002) begin nErr++; $display("FAIL cross_hold got %h want 00003002", fault_addr); end
`endif
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1;
    drive(1'b1, 3'b100, 32'h4000, 32'hFFFF_FFFF);
    #1;
    nCmp++; if (req_ready !== 1'b1) begin nErr++; $display("FAIL ill_ready got %b want 1", req_ready); end
    tick();
    drive(1'b1, 3'b011, 32'h5008, 32'h1234_5678);
    nCmp++; if (store_fault !== 1'b1 || fault_addr !== 32'h4000) begin nErr++; $display("FAIL ill_f3 got %b/%h want 1/00004000", store_fault, fault_addr); end
    nCmp++; if (count !== 3'd0) begin nErr++; $display("FAIL ill_count got %0d want 0", count); end
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (store_fault !== 1'b1 || fault_addr !== 32'h5008) begin nErr++; $display("FAIL ill_sd got %b/%h want 1/00005008", store_fault, fault_addr); end
    tick();
    nCmp++; if (store_fault !== 1'b0 || empty !== 1'b1) begin nErr++; $display("FAIL ill_after got fault=%b empty=%b want 0/1", store_fault, empty); end
  endtask

  task automatic test_midreset();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 32'h700 + 32'(k), 32'h0000_0077);
      tick();
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (count !== 3'd3) begin nErr++; $display("FAIL pre_reset_count got %0d want 3", count); end
    #2;
    RESETn = 1'b0;
    #1;
    nCmp++; if (count !== 3'd0 || empty !== 1'b1 || mem_valid !== 1'b0)
      begin nErr++; $display("FAIL async_reset got count=%0d empty=%b valid=%b want 0/1/0", count, empty, mem_valid); end
    tick();
    RESETn = 1'b1;
    mem_ready = 1'b1;
    tick();
    nCmp++; if (mem_valid !== 1'b0) begin nErr++; $display("FAIL post_reset_valid got %b want 0", mem_valid); end
    drive(1'b1, 3'b000, 32'h6001, 32'h0000_005A);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    nCmp++; if (mem_addr !== 32'h6000 || mem_wdata !== 32'h0000_5A00 || mem_wstrb !== 4'b0010 || count !== 3'd1)
      begin nErr++; $display("FAIL post_reset_sb got %h/%h/%b cnt=%0d want 00006000/00005a00/0010 cnt=1", mem_addr, mem_wdata, mem_wstrb, count); end
    tick();
    nCmp++; if (empty !== 1'b1) begin nErr++; $display("FAIL post_reset_drain got empty=%b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_full_drain();
    test_cross();
    test_illegal();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
